conv_window_3x3: RTL

Streaming 3x3 window generator that feeds the 3x3 floating-point convolution core. It accepts one 32-bit IEEE-754 pixel per valid cycle in raster order and buffers the two previous image rows in line buffers. For every pixel position where a full 3x3 neighbourhood exists ("valid" convolution, no padding), it emits all nine window taps in parallel with a valid strobe. Its outputs connect directly to the core's nine data inputs and its valid input.

---
 rtl/conv_window_3x3_pkg.sv | 15 +
 rtl/conv_window_3x3_line_buffer.sv | 29 ++
 rtl/conv_window_3x3.sv | 137 +++++++++++++
 3 files changed

// File: rtl/conv_window_3x3_pkg.sv
// Shared constants for the 3x3 window generator and the convolution core it feeds.
package conv_window_3x3_pkg;

    // Kernel size: 3x3 neighbourhood.
    localparam int CONV_K = 3;

    // Default pixel width (FP32 bit pattern, carried but never interpreted).
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Width of a counter/address that spans 0..n-1. Always at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_window_3x3_line_buffer.sv
// Single-port line buffer: combinational read, write on the rising edge.
// In the same cycle the old word is read and the new word is written.
// There is no reset: the contents are only trusted once a full row has been written.
module line_buffer
    import conv_window_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 28,
    localparam int ADDR_W    = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Write the accepted word. A read in the same cycle still returns the previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator. It takes raster-order pixels and keeps the two
// previous rows in line buffers. For every interior position (no padding) it
// presents all nine taps of the neighbourhood, one cycle after the pixel arrives.
module conv_window_3x3
    import conv_window_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Frame_Start,
    input  logic                  Valid_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic [DATA_WIDTH-1:0] Win0,
    output logic [DATA_WIDTH-1:0] Win1,
    output logic [DATA_WIDTH-1:0] Win2,
    output logic [DATA_WIDTH-1:0] Win3,
    output logic [DATA_WIDTH-1:0] Win4,
    output logic [DATA_WIDTH-1:0] Win5,
    output logic [DATA_WIDTH-1:0] Win6,
    output logic [DATA_WIDTH-1:0] Win7,
    output logic [DATA_WIDTH-1:0] Win8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    logic [COL_W-1:0] col, eff_col, col_nxt;
    logic [ROW_W-1:0] row, eff_row, row_nxt;
    logic             win_ok, last_px;

    logic [DATA_WIDTH-1:0] lb_a_rd, lb_b_rd;

    // Window taps: [row][column], row 0 = oldest line, column 2 = newest pixel.
    logic [DATA_WIDTH-1:0] win_p0 [CONV_K][CONV_K];
    logic                  vld_p0, done_p0;

    // Position of the current pixel. Frame_Start forces (0,0) for this cycle's pixel.
    // Next-position arithmetic with raster wrap, including wrap at the end of a frame.
    always_comb begin
        eff_col = Frame_Start ? '0 : col;
        eff_row = Frame_Start ? '0 : row;
        last_px = (eff_row == ROW_W'(IMG_H - 1)) && (eff_col == COL_W'(IMG_W - 1));
        win_ok  = (eff_row >= ROW_W'(CONV_K - 1)) && (eff_col >= COL_W'(CONV_K - 1));
        col_nxt = eff_col + COL_W'(1);
        row_nxt = eff_row;
        if (eff_col == COL_W'(IMG_W - 1)) begin
            col_nxt = '0;
            row_nxt = (eff_row == ROW_W'(IMG_H - 1)) ? '0 : eff_row + ROW_W'(1);
        end
    end

    // Position counters advance only on accepted pixels. A lone Frame_Start clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (Valid_In) begin
            col <= col_nxt;
            row <= row_nxt;
        end else if (Frame_Start) begin
            col <= '0;
            row <= '0;
        end
    end

    // lb_a holds row r-1. lb_b holds row r-2, and is fed by what lb_a held before this write.
    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W)
    ) u_lb_a (
        .clk   (clk),
        .we    (Valid_In),
        .addr  (eff_col),
        .wdata (Data_In),
        .rdata (lb_a_rd)
    );

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_W)
    ) u_lb_b (
        .clk   (clk),
        .we    (Valid_In),
        .addr  (eff_col),
        .wdata (lb_a_rd),
        .rdata (lb_b_rd)
    );

    // --- stage p0: window shift register, loaded with the new column on each accepted pixel ---
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int rr = 0; rr < CONV_K; rr++) begin
                for (int kk = 0; kk < CONV_K; kk++) begin
                    win_p0[rr][kk] <= '0;
                end
            end
        end else if (Valid_In) begin
            for (int rr = 0; rr < CONV_K; rr++) begin
                for (int kk = 0; kk < CONV_K - 1; kk++) begin
                    win_p0[rr][kk] <= win_p0[rr][kk+1];
                end
            end
            win_p0[0][CONV_K-1] <= lb_b_rd;
            win_p0[1][CONV_K-1] <= lb_a_rd;
            win_p0[2][CONV_K-1] <= Data_In;
        end
    end

    // Valid and frame-done strobes, aligned with the window they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
        end else begin
            vld_p0  <= Valid_In && win_ok;
            done_p0 <= Valid_In && win_ok && last_px;
        end
    end

    assign Win0       = win_p0[0][0];
    assign Win1       = win_p0[0][1];
    assign Win2       = win_p0[0][2];
    assign Win3       = win_p0[1][0];
    assign Win4       = win_p0[1][1];
    assign Win5       = win_p0[1][2];
    assign Win6       = win_p0[2][0];
    assign Win7       = win_p0[2][1];
    assign Win8       = win_p0[2][2];
    assign Valid_Out  = vld_p0;
    assign Frame_Done = done_p0;

endmodule
